// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, condition/sub-op codes, error codes, encoder states.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package isa_pkg;

  localparam int WORD_W = 9;

  typedef enum logic [2:0] {
    OP_STR    = 3'b000,
    OP_LDR    = 3'b001,
    OP_MOV    = 3'b010,
    OP_SHIFT  = 3'b011,
    OP_SADDTO = 3'b100,
    OP_JUMP   = 3'b101,
    OP_XOR    = 3'b110,
    OP_AND    = 3'b111
  } opcode_t;

  // JUMP sub-field: 0000 is the register compare form, the rest are branch / ALU conditions
  typedef enum logic [3:0] {
    CC_CMP  = 4'b0000,
    CC_BLE  = 4'b0100,
    CC_BLT  = 4'b0101,
    CC_BEQ  = 4'b0110,
    CC_BNE  = 4'b0111,
    CC_BGE  = 4'b1000,
    CC_BGT  = 4'b1010,
    CC_BR   = 4'b1011,
    CC_ADD1 = 4'b1100,
    CC_ADD2 = 4'b1101,
    CC_SUB1 = 4'b1110,
    CC_BOF  = 4'b1111
  } cond_t;

  typedef enum logic [1:0] {
    SA_ADD  = 2'd0,
    SA_SUB  = 2'd1,
    SA_COPY = 2'd2,
    SA_ABS  = 2'd3
  } saddto_op_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_RANGE  = 2'd1,
    ERR_BADSUB = 2'd2,
    ERR_FULL   = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } encoder_state_t;

  // True for every JUMP sub value that has a defined meaning (compare form included)
  function automatic logic cond_legal(input logic [3:0] sub);
    logic ok;
    ok = 1'b0;
    case (sub)
      CC_CMP, CC_BLE, CC_BLT, CC_BEQ, CC_BNE, CC_BGE,
      CC_BGT, CC_BR, CC_ADD1, CC_ADD2, CC_SUB1, CC_BOF: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encode_word.sv
// Packs symbolic instruction fields into a 9-bit word and flags illegal field combinations.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is consumed.
module instr_encode_word
  import isa_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [3:0]        sub,
  input  logic [1:0]        rd,
  input  logic [1:0]        ra,
  input  logic [1:0]        rb,
  input  logic [3:0]        imm,
  output logic [WORD_W-1:0] word,
  output err_code_t         err
);

  // Left shifts are stored as the two's-complement of the amount; 8 maps to 1000
  logic [3:0] neg_imm;
  assign neg_imm = ~imm + 4'd1;

  // Per-opcode field packing and legality check; opcode always occupies bits [8:6]
  always_comb begin
    word = {op, 6'b0};
    err  = ERR_NONE;
    case (opcode_t'(op))
      OP_STR, OP_LDR: begin
        word[5:0] = {rd, ra, imm[1:0]};
        if (imm > 4'd3) err = ERR_RANGE;
      end
      OP_MOV: begin
        word[5:0] = {rd, imm};
      end
      OP_SHIFT: begin
        if (sub[0]) begin
          // Left 0 yields 0000, i.e. the same word as right 0
          word[5:0] = {rd, neg_imm};
          if (imm > 4'd8) err = ERR_RANGE;
        end else begin
          word[5:0] = {rd, imm};
          if (imm > 4'd7) err = ERR_RANGE;
        end
      end
      OP_SADDTO: begin
        word[5:0] = {sub[1:0], rd, rb};
        if (sub[3:2] != 2'b00) err = ERR_BADSUB;
      end
      OP_JUMP: begin
        if (sub == CC_CMP) begin
          word[5:0] = {2'b00, ra, rb};
        end else begin
          word[5:0] = {sub, rb};
          if (!cond_legal(sub)) err = ERR_BADSUB;
        end
      end
      OP_XOR, OP_AND: begin
        word[5:0] = {rd, ra, rb};
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Accepts instruction requests, encodes them and writes legal words to imem at an incrementing address.
// Latency: 1 cycle from accept to imem write or error pulse; one request per cycle sustained.
// Backpressure: req_ready is high only in RUN; FULL drops ready and pulses one FULL error.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [3:0]        req_sub,
  input  logic [1:0]        req_rd,
  input  logic [1:0]        req_ra,
  input  logic [1:0]        req_rb,
  input  logic [3:0]        req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [8:0]        imem_wdata,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output logic              done
);

  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  encoder_state_t    state, state_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              full_err_sent;
  logic [8:0]        enc_word;
  err_code_t         enc_err;
  logic              accept, legal_acc, illegal_acc, last_slot, start_ok, full_err_fire;
  logic              we_q, err_vld_q;
  err_code_t         err_code_q;

  instr_encode_word u_enc (
    .op   (req_op),
    .sub  (req_sub),
    .rd   (req_rd),
    .ra   (req_ra),
    .rb   (req_rb),
    .imm  (req_imm),
    .word (enc_word),
    .err  (enc_err)
  );

  assign req_ready     = (state == ST_RUN);
  assign accept        = req_valid && req_ready;
  assign legal_acc     = accept && (enc_err == ERR_NONE);
  assign illegal_acc   = accept && (enc_err != ERR_NONE);
  // Last slot of the run, either by depth or by hitting the top of the address space
  assign last_slot     = (word_count == LAST_CNT) || (wr_addr == TOP_ADDR);
  assign start_ok      = start && (state != ST_RUN);
  assign full_err_fire = (state == ST_FULL) && req_valid && !full_err_sent && !start;
  assign done          = (state == ST_FULL);
  // Registered strobes are masked while reset is held so an in-flight write never lands
  assign imem_we       = we_q && !reset;
  assign err_valid     = err_vld_q && !reset;
  assign err_code      = err_code_q;

  // Next-state logic: start leaves IDLE/FULL, filling the last slot enters FULL
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (legal_acc && last_slot) state_nxt = ST_FULL;
      ST_FULL: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Write address, word count and the one-shot FULL error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr       <= '0;
      word_count    <= '0;
      full_err_sent <= 1'b0;
    end else if (start_ok) begin
      wr_addr       <= start_addr;
      word_count    <= '0;
      full_err_sent <= 1'b0;
    end else begin
      if (legal_acc) begin
        wr_addr    <= wr_addr + ADDR_ONE;
        word_count <= word_count + CNT_ONE;
      end
      if (full_err_fire) full_err_sent <= 1'b1;
    end
  end

  // Output register stage: one-cycle write strobe or error pulse per accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      err_vld_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      we_q      <= legal_acc;
      err_vld_q <= illegal_acc || full_err_fire;
      if (illegal_acc)        err_code_q <= enc_err;
      else if (full_err_fire) err_code_q <= ERR_FULL;
      else                    err_code_q <= ERR_NONE;
      if (legal_acc) begin
        imem_addr  <= wr_addr;
        imem_wdata <= enc_word;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a scoreboard of expected writes / error pulses.
// Latency: expectations are queued at drive time and popped when an output strobe appears.
// Backpressure: requests held while req_ready is low are retried by repeating the step.
module tb_instr_encoder;
  import isa_pkg::*;

  typedef struct {
    logic       is_err;
    logic [7:0] addr;
    logic [8:0] data;
    logic [1:0] code;
  } exp_t;

  logic       clk, reset, start, req_valid, req_ready;
  logic [7:0] start_addr;
  logic [2:0] req_op;
  logic [3:0] req_sub, req_imm;
  logic [1:0] req_rd, req_ra, req_rb;
  logic       imem_we, err_valid, done;
  logic [7:0] imem_addr;
  logic [8:0] imem_wdata;
  logic [1:0] err_code;
  logic [8:0] word_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_sub    (req_sub),
    .req_rd     (req_rd),
    .req_ra     (req_ra),
    .req_rb     (req_rb),
    .req_imm    (req_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .word_count (word_count),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [8:0] d);
    exp_t e;
    e.is_err = 1'b0; e.addr = a; e.data = d; e.code = 2'd0;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1; e.addr = 8'h0; e.data = 9'h0; e.code = c;
    sb.push_back(e);
  endtask

  // Present one request for one clock edge; valid stays high until the caller drops it
  task automatic send(input logic [2:0] op, input logic [3:0] sub, input logic [1:0] rd,
                      input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] imm);
    req_op = op; req_sub = sub; req_rd = rd; req_ra = ra; req_rb = rb; req_imm = imm;
    req_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] a);
    start = 1'b1; start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk(tag, 16'(sb.size()), 16'd0);
  endtask

  // Scoreboard monitor: every write or error pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    logic have;
    if (imem_we === 1'b1 || err_valid === 1'b1) begin
      have = (sb.size() != 0);
      chk("sb_pending", 16'(have), 16'd1);
      if (have) begin
        e = sb.pop_front();
        if (!e.is_err) begin
          chk("wr_we", 16'(imem_we), 16'd1);
          chk("wr_errv", 16'(err_valid), 16'd0);
          chk("wr_addr", 16'(imem_addr), 16'(e.addr));
          chk("wr_data", 16'(imem_wdata), 16'(e.data));
        end else begin
          chk("err_v", 16'(err_valid), 16'd1);
          chk("err_we", 16'(imem_we), 16'd0);
          chk("err_code", 16'(err_code), 16'(e.code));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = 8'h0; req_valid = 1'b0;
    req_op = 3'd0; req_sub = 4'd0; req_rd = 2'd0; req_ra = 2'd0; req_rb = 2'd0; req_imm = 4'd0;

    // Reset state
    do_reset();
    chk("rst_ready", 16'(req_ready), 16'd0);
    chk("rst_we", 16'(imem_we), 16'd0);
    chk("rst_errv", 16'(err_valid), 16'd0);
    chk("rst_errc", 16'(err_code), 16'd0);
    chk("rst_addr", 16'(imem_addr), 16'd0);
    chk("rst_wdata", 16'(imem_wdata), 16'd0);
    chk("rst_count", 16'(word_count), 16'd0);
    chk("rst_done", 16'(done), 16'd0);

    // MOV rd=2 imm=9 at 0x10
    do_start(8'h10);
    chk("start_ready", 16'(req_ready), 16'd1);
    push_wr(8'h10, 9'b010_10_1001);
    send(3'b010, 4'd0, 2'd2, 2'd0, 2'd0, 4'd9);
    chk("mov_count", 16'(word_count), 16'd1);
    drain("drain_mov");

    // Back-to-back shifts, then BADSUB jump and a Beq reusing the slot, then bad SADDTO sub
    do_reset();
    do_start(8'h10);
    push_wr(8'h10, 9'b011_01_0011);
    send(3'b011, 4'b0000, 2'd1, 2'd0, 2'd0, 4'd3);
    push_wr(8'h11, 9'b011_01_1000);
    send(3'b011, 4'b0001, 2'd1, 2'd0, 2'd0, 4'd8);
    push_err(2'd2);
    send(3'b101, 4'b1001, 2'd0, 2'd0, 2'd3, 4'd0);
    chk("badsub_count", 16'(word_count), 16'd2);
    push_wr(8'h12, 9'b101_0110_11);
    send(3'b101, 4'b0110, 2'd0, 2'd0, 2'd3, 4'd0);
    push_err(2'd2);
    send(3'b100, 4'b0101, 2'd1, 2'd0, 2'd2, 4'd0);
    chk("saddto_bad_count", 16'(word_count), 16'd3);
    drain("drain_shift_jump");
    chk("g2_done", 16'(done), 16'd0);

    // RANGE errors and legal forms until the run fills at DEPTH=4
    do_reset();
    do_start(8'h10);
    push_err(2'd1);
    send(3'b001, 4'd0, 2'd3, 2'd1, 2'd0, 4'd5);
    push_wr(8'h10, 9'b001_11_01_10);
    send(3'b001, 4'd0, 2'd3, 2'd1, 2'd0, 4'd2);
    push_err(2'd1);
    send(3'b011, 4'b0000, 2'd2, 2'd0, 2'd0, 4'd8);
    push_err(2'd1);
    send(3'b011, 4'b0001, 2'd2, 2'd0, 2'd0, 4'd9);
    push_wr(8'h11, 9'b011_10_0000);
    send(3'b011, 4'b0001, 2'd2, 2'd0, 2'd0, 4'd0);
    push_wr(8'h12, 9'b101_00_10_01);
    send(3'b101, 4'b0000, 2'd0, 2'd2, 2'd1, 4'd0);
    push_wr(8'h13, 9'b100_11_01_10);
    send(3'b100, 4'b0011, 2'd1, 2'd0, 2'd2, 4'd0);
    chk("g3_done", 16'(done), 16'd1);
    chk("g3_ready", 16'(req_ready), 16'd0);
    drain("drain_range");

    // FULL -> start at 0, five requests: four writes, fifth held and one FULL error
    do_start(8'h00);
    chk("restart_ready", 16'(req_ready), 16'd1);
    chk("restart_count", 16'(word_count), 16'd0);
    push_wr(8'h00, 9'b110_01_10_11);
    send(3'b110, 4'd0, 2'd1, 2'd2, 2'd3, 4'd0);
    push_wr(8'h01, 9'b111_11_00_01);
    send(3'b111, 4'd0, 2'd3, 2'd0, 2'd1, 4'd0);
    push_wr(8'h02, 9'b010_00_1111);
    send(3'b010, 4'd0, 2'd0, 2'd0, 2'd0, 4'd15);
    push_wr(8'h03, 9'b000_10_11_01);
    send(3'b000, 4'd0, 2'd2, 2'd3, 2'd0, 4'd1);
    chk("full_done", 16'(done), 16'd1);
    chk("full_ready", 16'(req_ready), 16'd0);
    chk("full_count", 16'(word_count), 16'd4);
    push_err(2'd3);
    for (int i = 0; i < 3; i++) send(3'b010, 4'd0, 2'd1, 2'd0, 2'd0, 4'd7);
    drain("drain_full");
    do_start(8'h20);
    chk("resume_ready", 16'(req_ready), 16'd1);
    push_wr(8'h20, 9'b010_01_0111);
    send(3'b010, 4'd0, 2'd1, 2'd0, 2'd0, 4'd7);
    drain("drain_resume");

    // Top of address space ends the run before DEPTH
    do_reset();
    do_start(8'hFE);
    push_wr(8'hFE, 9'b010_11_0001);
    send(3'b010, 4'd0, 2'd3, 2'd0, 2'd0, 4'd1);
    push_wr(8'hFF, 9'b010_11_0010);
    send(3'b010, 4'd0, 2'd3, 2'd0, 2'd0, 4'd2);
    chk("top_done", 16'(done), 16'd1);
    chk("top_count", 16'(word_count), 16'd2);
    drain("drain_top");

    // Reset in the cycle after an accept suppresses the pending write
    do_reset();
    do_start(8'h10);
    send(3'b010, 4'd0, 2'd2, 2'd0, 2'd0, 4'd9);
    req_valid = 1'b0;
    reset = 1'b1;
    #1 chk("midrst_we", 16'(imem_we), 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_we_after", 16'(imem_we), 16'd0);
    chk("midrst_ready", 16'(req_ready), 16'd0);
    chk("midrst_count", 16'(word_count), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    drain("drain_midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
